// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, registered ALU: one operation in flight at a time.
// Build option: define ALU_ARB_ILLEGAL_CHK_EN to answer opcodes above 8 with an error response instead of executing them.
module alu_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_funct,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_funct,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q;
    logic        ptr_q;
    logic [3:0]  cnt_q;
    logic        rspValid_q;
    logic [31:0] rspData_q;
    logic        rspId_q;
    logic        rspErr_q;
    logic [31:0] aluA_q;
    logic [31:0] aluB_q;
    logic [4:0]  aluShamt_q;
    logic [3:0]  aluFunct_q;

    logic        canAccept;
    logic        accept;
    logic        winId_d;
    logic [3:0]  winFunct_d;
    logic [31:0] winA_d;
    logic [31:0] winB_d;
    logic [4:0]  winShamt_d;
    logic        illegalOp;

    // Readies are gated by rst_n so nothing looks grantable while reset is held.
    assign canAccept  = rst_n && (state_q == IDLE);
    assign req0_ready = canAccept && req0_valid && (!ptr_q || !req1_valid);
    assign req1_ready = canAccept && req1_valid && (ptr_q || !req0_valid);
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        winId_d    = req1_ready;
        winFunct_d = req0_funct;
        winA_d     = req0_a;
        winB_d     = req0_b;
        winShamt_d = req0_shamt;
        if (req1_ready) begin
            winFunct_d = req1_funct;
            winA_d     = req1_a;
            winB_d     = req1_b;
            winShamt_d = req1_shamt;
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    assign illegalOp = (winFunct_d > 4'd8);
`else
    assign illegalOp = 1'b0;
`endif

    // Illegal opcodes jump straight to RESP and leave the ALU drive untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= 4'd0;
            rspValid_q <= 1'b0;
            rspData_q  <= 32'd0;
            rspId_q    <= 1'b0;
            rspErr_q   <= 1'b0;
            aluA_q     <= 32'd0;
            aluB_q     <= 32'd0;
            aluShamt_q <= 5'd0;
            aluFunct_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rspId_q <= winId_d;
                        ptr_q   <= !winId_d;
                        if (illegalOp) begin
                            rspErr_q   <= 1'b1;
                            rspData_q  <= 32'd0;
                            rspValid_q <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            aluFunct_q <= winFunct_d;
                            aluA_q     <= winA_d;
                            aluB_q     <= winB_d;
                            aluShamt_q <= winShamt_d;
                            cnt_q      <= 4'(LAT);
                            rspErr_q   <= 1'b0;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rspData_q  <= alu_res;
                        rspValid_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a     = aluA_q;
    assign alu_b     = aluB_q;
    assign alu_shamt = aluShamt_q;
    assign alu_funct = aluFunct_q;
    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign rsp_id    = rspId_q;
    assign rsp_err   = rspErr_q;
    assign busy      = (state_q != IDLE);

endmodule
